// File: rtl/systolic_skew_feeder.sv
// Transmit-side feeder for the 3x3 systolic array: buffers one A/B tile and streams it diagonally skewed.
// Optional macro SKEW_FEEDER_REPLAY_EN adds a replay input that re-streams the stored tile.
module systolic_skew_feeder #(
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [3*DATA_W-1:0] a_row,
  input  logic [3*DATA_W-1:0] b_row,
`ifdef SKEW_FEEDER_REPLAY_EN
  input  logic                replay,
`endif
  output logic [DATA_W-1:0]   side_1,
  output logic [DATA_W-1:0]   side_2,
  output logic [DATA_W-1:0]   side_3,
  output logic [DATA_W-1:0]   ceiling_1,
  output logic [DATA_W-1:0]   ceiling_2,
  output logic [DATA_W-1:0]   ceiling_3,
  output logic                en,
  output logic                array_clr,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, FEED, DRAIN, DONE} state_t;

  // One counter serves as beat index, FEED time step and drain count.
  localparam int CNT_W = (DRAIN_CYCLES > 7) ? $clog2(DRAIN_CYCLES + 1) : 3;
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(4);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [DATA_W-1:0] a_mem [3][3];
  logic [DATA_W-1:0] b_mem [3][3];
  logic             beat;
  logic             replay_req;
  logic [1:0]       wr_row;

  assign beat   = load_valid && load_ready;
  assign wr_row = (state_reg == LOAD) ? cnt_reg[1:0] : 2'd0;

`ifdef SKEW_FEEDER_REPLAY_EN
  assign replay_req = replay;
`else
  assign replay_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
        end
      end
    end else if (beat) begin
      for (int c = 0; c < 3; c++) begin
        a_mem[wr_row][c] <= a_row[c*DATA_W +: DATA_W];
        b_mem[wr_row][c] <= b_row[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        // A load beat takes priority over a replay request.
        if (beat) begin
          state_next = LOAD;
          cnt_next   = CNT_W'(1);
        end else if (replay_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      LOAD: begin
        if (beat) begin
          if (cnt_reg == CNT_W'(2)) begin
            state_next = CLEAR;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      CLEAR: begin
        state_next = FEED;
        cnt_next   = '0;
      end
      FEED: begin
        if (cnt_reg == FEED_LAST) begin
          state_next = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_reg == DRAIN_LAST) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_ready <= 1'b0;
      busy       <= 1'b0;
      en         <= 1'b0;
      array_clr  <= 1'b0;
      done       <= 1'b0;
    end else begin
      load_ready <= (state_next == IDLE) || (state_next == LOAD);
      busy       <= (state_next != IDLE);
      en         <= (state_next == FEED) || (state_next == DRAIN);
      array_clr  <= (state_next == CLEAR);
      done       <= (state_next == DONE);
    end
  end

  // Lane gi is delayed by gi cycles; a negative offset wraps to a large value and fails the range test.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    localparam logic [CNT_W:0] LANE_OFS = (CNT_W + 1)'(gi);
    logic [CNT_W:0]    diff;
    logic              hit;
    logic [DATA_W-1:0] side_d, ceil_d;
    logic [DATA_W-1:0] side_reg, ceil_reg;

    assign diff   = {1'b0, cnt_next} - LANE_OFS;
    assign hit    = (state_next == FEED) && (diff <= (CNT_W + 1)'(2));
    assign side_d = hit ? a_mem[gi][diff[1:0]] : '0;
    assign ceil_d = hit ? b_mem[diff[1:0]][gi] : '0;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        side_reg <= '0;
        ceil_reg <= '0;
      end else begin
        side_reg <= side_d;
        ceil_reg <= ceil_d;
      end
    end
  end

  assign side_1    = g_lane[0].side_reg;
  assign side_2    = g_lane[1].side_reg;
  assign side_3    = g_lane[2].side_reg;
  assign ceiling_1 = g_lane[0].ceil_reg;
  assign ceiling_2 = g_lane[1].ceil_reg;
  assign ceiling_3 = g_lane[2].ceil_reg;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized self-checking bench for systolic_skew_feeder against a cycle-indexed tile timeline model.
module tb_systolic_skew_feeder;

  localparam int DATA_W = 8;
  localparam int DRAIN  = 3;
  localparam int N_DONE = 7 + DRAIN;   // cycle index of done after the 3rd beat
  localparam int N_IDLE = 8 + DRAIN;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                load_valid = 1'b0;
  logic [3*DATA_W-1:0] a_row = '0;
  logic [3*DATA_W-1:0] b_row = '0;
`ifdef SKEW_FEEDER_REPLAY_EN
  logic                replay = 1'b0;
`endif
  logic                load_ready, en, array_clr, busy, done;
  logic [DATA_W-1:0]   side_1, side_2, side_3, ceiling_1, ceiling_2, ceiling_3;

  systolic_skew_feeder #(.DATA_W(DATA_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .a_row(a_row), .b_row(b_row),
`ifdef SKEW_FEEDER_REPLAY_EN
    .replay(replay),
`endif
    .side_1(side_1), .side_2(side_2), .side_3(side_3),
    .ceiling_1(ceiling_1), .ceiling_2(ceiling_2), .ceiling_3(ceiling_3),
    .en(en), .array_clr(array_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] ma [3][3];
  logic [DATA_W-1:0] mb [3][3];
  int acc;

  // Behavioural stand-in for the array's PE(1,1) accumulator.
  always @(posedge clk or negedge rst) begin
    if (!rst)          acc <= 0;
    else if (array_clr) acc <= 0;
    else if (en)       acc <= acc + int'(side_1) * int'(ceiling_1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_ready);
    check({tag, " side_1"}, side_1, 0);
    check({tag, " side_2"}, side_2, 0);
    check({tag, " side_3"}, side_3, 0);
    check({tag, " ceiling_1"}, ceiling_1, 0);
    check({tag, " ceiling_2"}, ceiling_2, 0);
    check({tag, " ceiling_3"}, ceiling_3, 0);
    check({tag, " en"}, en, 0);
    check({tag, " array_clr"}, array_clr, 0);
    check({tag, " done"}, done, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " load_ready"}, load_ready, exp_ready);
  endtask

  // Compare outputs in cycle n after the 3rd beat (n=1 is the clear cycle).
  task automatic check_cycle(input int n);
    int t;
    int pe_sum;
    logic [DATA_W-1:0] es [3];
    logic [DATA_W-1:0] ec [3];
    logic [DATA_W-1:0] gs [3];
    logic [DATA_W-1:0] gc [3];
    t  = n - 2;
    gs = '{side_1, side_2, side_3};
    gc = '{ceiling_1, ceiling_2, ceiling_3};
    for (int i = 0; i < 3; i++) begin
      es[i] = '0;
      ec[i] = '0;
      if (n >= 2 && n <= 6 && t - i >= 0 && t - i <= 2) begin
        es[i] = ma[i][t-i];
        ec[i] = mb[t-i][i];
      end
      check($sformatf("side_%0d n=%0d", i + 1, n), gs[i], es[i]);
      check($sformatf("ceiling_%0d n=%0d", i + 1, n), gc[i], ec[i]);
    end
    check($sformatf("en n=%0d", n), en, (n >= 2 && n <= N_DONE - 1));
    check($sformatf("array_clr n=%0d", n), array_clr, (n == 1));
    check($sformatf("done n=%0d", n), done, (n == N_DONE));
    check($sformatf("busy n=%0d", n), busy, (n <= N_DONE));
    check($sformatf("load_ready n=%0d", n), load_ready, (n == N_IDLE));
    if (n == N_DONE) begin
      pe_sum = 0;
      for (int k = 0; k < 3; k++) pe_sum += int'(ma[0][k]) * int'(mb[k][0]);
      check("pe11 at done", acc, pe_sum);
      $display("tile done: pe11=%0d expected=%0d", acc, pe_sum);
    end
  endtask

  // Walk the post-load timeline; stray beats are driven throughout and must be ignored.
  task automatic check_run(input int abort_n, output bit aborted);
    aborted = 1'b0;
    for (int n = 1; n <= N_IDLE; n++) begin
      if (n == abort_n) begin
        rst = 1'b0;
        #1;
        check_idle_outputs($sformatf("abort n=%0d", n), 1'b0);
        load_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("post-abort busy", busy, 0);
        check("post-abort load_ready", load_ready, 1);
        $display("tile aborted by reset at n=%0d", n);
        aborted = 1'b1;
        return;
      end
      check_cycle(n);
      if (n < N_IDLE) begin
        load_valid = (n == N_DONE) ? 1'b1 : 1'($urandom_range(0, 1));
        a_row      = 24'($urandom);
        b_row      = 24'($urandom);
        step();
      end else begin
        load_valid = 1'b0;
      end
    end
  endtask

  task automatic run_tile(input int gap_before, input int abort_n, input bit do_replay);
    bit aborted;
    for (int k = 0; k < 3; k++) begin
      if (k == gap_before) begin
        repeat (4) begin
          load_valid = 1'b0;
          a_row      = 24'($urandom);
          step();
          check($sformatf("hold ready k=%0d", k), load_ready, 1);
          check($sformatf("hold busy k=%0d", k), busy, (k > 0));
        end
      end
      load_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
        a_row[j*DATA_W +: DATA_W] = ma[k][j];
        b_row[j*DATA_W +: DATA_W] = mb[k][j];
      end
      step();
      if (k < 2) begin
        check($sformatf("beat%0d ready", k), load_ready, 1);
        check($sformatf("beat%0d busy", k), busy, 1);
      end
    end
    load_valid = 1'b0;
    check_run(abort_n, aborted);
`ifdef SKEW_FEEDER_REPLAY_EN
    if (do_replay && !aborted) begin
      replay = 1'b1;
      step();
      replay = 1'b0;
      $display("replay issued");
      check_run(0, aborted);
    end
`else
    if (do_replay) $display("replay not built; skipped");
`endif
  endtask

  task automatic fill_fixed();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma[i][j] = DATA_W'(3 * i + j + 1);
        mb[i][j] = DATA_W'(10 + 3 * i + j);
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma[i][j] = DATA_W'($urandom);
        mb[i][j] = DATA_W'($urandom);
      end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("in reset", 1'b0);
    rst = 1'b1;
    step();
    check("after reset busy", busy, 0);
    check("after reset load_ready", load_ready, 1);

    fill_fixed();
    run_tile(-1, 0, 1'b0);
    $display("fixed tile streamed");
    run_tile(2, 0, 1'b0);
    $display("fixed tile with backpressure streamed");

    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma[i][j] = 8'd1;
        mb[i][j] = 8'd2;
      end
    run_tile(-1, 0, 1'b0);
    check("ones x twos pe11", acc, 6);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_tile($urandom_range(0, 3) == 3 ? -1 : int'($urandom_range(0, 2)), 0, 1'b0);
      $display("random tile %0d streamed", r);
    end

    fill_random();
    run_tile(-1, 4, 1'b0);

    fill_fixed();
    run_tile(-1, 0, 1'b1);

    fill_random();
    run_tile(1, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
